// File: rtl/stress_window_reader.sv
// Read-side controller for the classification tally counter: frames trigger windows,
// clears the counter, samples its count at window end and offers a stress decision.
module stress_window_reader #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned WIN_LEN = 1024,
    parameter int unsigned THRESH  = 512,
    parameter int unsigned IDX_W   = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             enable,
    input  logic             trigger,
    input  logic [CNT_W-1:0] count,
    output logic             init,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             stress_flag,
    output logic [CNT_W-1:0] result_count,
    output logic [IDX_W-1:0] window_idx,
    output logic             overrun,
    output logic             lost_trig
);

    localparam int unsigned     SC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [SC_W-1:0]  LAST = SC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);

    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, CAPTURE} state_t;

    state_t          state;
    logic [SC_W-1:0] sample_cnt;

    // init is registered, so it is raised on the transition into CLEAR or CAPTURE
    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= IDLE;
            sample_cnt   <= '0;
            init         <= 1'b0;
            result_valid <= 1'b0;
            stress_flag  <= 1'b0;
            result_count <= '0;
            window_idx   <= '0;
            overrun      <= 1'b0;
            lost_trig    <= 1'b0;
        end else begin
            init <= 1'b0;
            if (trigger && init) begin
                lost_trig <= 1'b1;
            end
            if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= CLEAR;
                        init  <= 1'b1;
                    end
                end
                CLEAR: begin
                    sample_cnt <= '0;
                    state      <= enable ? ACCUM : IDLE;
                end
                ACCUM: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (trigger) begin
                        if (sample_cnt == LAST) begin
                            state <= CAPTURE;
                            init  <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + SC_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    // a load in the same cycle as a transfer keeps valid high without overrun
                    result_count <= count;
                    stress_flag  <= (count >= THR);
                    window_idx   <= window_idx + IDX_W'(1);
                    result_valid <= 1'b1;
                    if (result_valid && !result_ready) begin
                        overrun <= 1'b1;
                    end
                    sample_cnt <= '0;
                    state      <= enable ? ACCUM : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
